// File: rtl/ex_dest_pipe_tracker.sv
// EX-stage destination select plus a DEPTH-deep valid/dest tracker (EX/MEM .. WB)
// with nearest-match lookup of two decode-stage sources against in-flight writes.

module ex_dest_stage #(
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              clear,
   input  logic              d_vld,
   input  logic [ADDR_W-1:0] d_dest,
   output logic              q_vld,
   output logic [ADDR_W-1:0] q_dest
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_vld  <= 1'b0;
         q_dest <= '0;
      end else if (load) begin
         q_vld  <= d_vld;
         q_dest <= d_dest;
      end else if (clear) begin
         q_vld  <= 1'b0;
         q_dest <= '0;
      end
   end

endmodule

module ex_dest_pipe_tracker #(
   parameter int ADDR_W   = 5,
   parameter int DEPTH    = 3,
   parameter int LINK_REG = 31,
   localparam int DIST_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] dest_rt,
   input  logic [ADDR_W-1:0] dest_rd,
   input  logic [1:0]        dest_sel,
   input  logic              reg_write,
   input  logic              in_valid,
   input  logic              hold,
   input  logic              flush,
   input  logic [ADDR_W-1:0] src_a,
   input  logic [ADDR_W-1:0] src_b,
   output logic [ADDR_W-1:0] ex_dest,
   output logic [ADDR_W-1:0] mem_dest,
   output logic              mem_dest_vld,
   output logic [ADDR_W-1:0] wb_dest,
   output logic              wb_dest_vld,
   output logic [DIST_W-1:0] dist_a,
   output logic [DIST_W-1:0] dist_b
);

   logic [DEPTH-1:0]             vld_pipe;
   logic [DEPTH-1:0][ADDR_W-1:0] dest_pipe;
   logic                         entry_vld;
   logic [ADDR_W-1:0]            entry_dest;

   always_comb begin
      ex_dest = '0;
      case (dest_sel)
         2'b00:   ex_dest = dest_rt;
         2'b01:   ex_dest = dest_rd;
         2'b10:   ex_dest = ADDR_W'(LINK_REG);
         default: ex_dest = '0;
      endcase
   end

   // r0 writes are dropped here so the lookup never needs a zero check on dest
   assign entry_vld  = in_valid & reg_write & (dest_sel != 2'b11) & (ex_dest != '0) & ~flush;
   assign entry_dest = entry_vld ? ex_dest : '0;

   // Flush overrides hold on stage 0 only; older stages are already committed.
   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_stage
         if (i == 0) begin : g_head
            ex_dest_stage #(.ADDR_W(ADDR_W)) u_stage (
               .clk    (clk),
               .rst_n  (rst_n),
               .load   (~hold),
               .clear  (hold & flush),
               .d_vld  (entry_vld),
               .d_dest (entry_dest),
               .q_vld  (vld_pipe[0]),
               .q_dest (dest_pipe[0])
            );
         end else begin : g_body
            ex_dest_stage #(.ADDR_W(ADDR_W)) u_stage (
               .clk    (clk),
               .rst_n  (rst_n),
               .load   (~hold),
               .clear  (1'b0),
               .d_vld  (vld_pipe[i-1]),
               .d_dest (dest_pipe[i-1]),
               .q_vld  (vld_pipe[i]),
               .q_dest (dest_pipe[i])
            );
         end
      end
   endgenerate

   assign mem_dest     = dest_pipe[0];
   assign mem_dest_vld = vld_pipe[0];
   assign wb_dest      = dest_pipe[DEPTH-1];
   assign wb_dest_vld  = vld_pipe[DEPTH-1];

   // Scan oldest to youngest so the youngest match is the last one written.
   always_comb begin
      dist_a = '0;
      dist_b = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (vld_pipe[i] && dest_pipe[i] == src_a && src_a != '0) dist_a = DIST_W'(i + 1);
         if (vld_pipe[i] && dest_pipe[i] == src_b && src_b != '0) dist_b = DIST_W'(i + 1);
      end
   end

endmodule
